// File: rtl/segments_decoder_if.sv
// Segment bus and decoded-value bundle for the two-digit 7-seg reader.
// The source side drives the multiplexed bus; the decoder drives the results.
interface segments_decoder_if;
  logic [6:0] seg_in;
  logic [1:0] dig_sel;
  logic [5:0] value;
  logic [3:0] tens_bcd;
  logic [3:0] units_bcd;
  logic       value_valid;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output seg_in,
    output dig_sel,
    input  value,
    input  tens_bcd,
    input  units_bcd,
    input  value_valid,
    input  err,
    input  err_code
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    output value,
    output tens_bcd,
    output units_bcd,
    output value_valid,
    output err,
    output err_code
  );
endinterface

// File: rtl/segments_decoder.sv
// Two-digit seven-segment bus reader: debounces each digit,
// decodes to BCD and assembles a binary value 0..59.
module segments_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  segments_decoder_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_TENS,
    WAIT_UNITS,
    EMIT
  } state_t;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1111110: r = {1'b1, 4'd0};
      7'b0110000: r = {1'b1, 4'd1};
      7'b1101101: r = {1'b1, 4'd2};
      7'b1111001: r = {1'b1, 4'd3};
      7'b0110011: r = {1'b1, 4'd4};
      7'b1011011: r = {1'b1, 4'd5};
      7'b1011111: r = {1'b1, 4'd6};
      7'b1110000: r = {1'b1, 4'd7};
      7'b1111111: r = {1'b1, 4'd8};
      7'b1111011: r = {1'b1, 4'd9};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  logic [6:0]    seg_q, seg_d;
  logic [1:0]    sel_q, sel_d;
  logic [6:0]    seg_p_q, seg_p_d;
  logic [1:0]    sel_p_q, sel_p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t        state_q, state_d;
  logic [3:0]    tens_l_q, tens_l_d;
  logic [3:0]    units_l_q, units_l_d;
  logic [5:0]    value_q, value_d;
  logic [3:0]    tens_bcd_q, tens_bcd_d;
  logic [3:0]    units_bcd_q, units_bcd_d;
  logic          vv_q, vv_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic       sel_ok;
  logic       same;
  logic       acc;
  logic       acc_tens;
  logic       acc_units;
  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_dig;

  // Run-length of identical selected samples; accept on first reach.
  always_comb begin
    seg_d   = bus.seg_in;
    sel_d   = bus.dig_sel;
    seg_p_d = seg_q;
    sel_p_d = sel_q;
    sel_ok  = (sel_q == 2'b10) || (sel_q == 2'b01);
    same    = sel_ok && (sel_q == sel_p_q) && (seg_q == seg_p_q);
    cnt_d   = '0;
    if (sel_ok) begin
      if (!same) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CW'(STABLE_CYCLES)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    acc = sel_ok && (cnt_d == CW'(STABLE_CYCLES))
        && !(same && (cnt_q == CW'(STABLE_CYCLES)));
    acc_tens  = acc && (sel_q == 2'b10);
    acc_units = acc && (sel_q == 2'b01);
    dec     = decode(seg_q);
    dec_ok  = dec[4];
    dec_dig = dec[3:0];
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    tens_l_d    = tens_l_q;
    units_l_d   = units_l_q;
    value_d     = value_q;
    tens_bcd_d  = tens_bcd_q;
    units_bcd_d = units_bcd_q;
    vv_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    unique case (state_q)
      WAIT_TENS: begin
        if (acc_tens) begin
          if (dec_ok) begin
            tens_l_d = dec_dig;
            tmo_d    = '0;
            state_d  = WAIT_UNITS;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      WAIT_UNITS: begin
        tmo_d = tmo_q + TW'(1);
        if (acc_units) begin
          if (dec_ok) begin
            units_l_d = dec_dig;
            state_d   = EMIT;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = WAIT_TENS;
          end
        end else if (acc_tens) begin
          if (dec_ok) begin
            tens_l_d = dec_dig;
            tmo_d    = '0;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = WAIT_TENS;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = WAIT_TENS;
        end
      end
      EMIT: begin
        state_d = WAIT_TENS;
        if (tens_l_q > 4'd5) begin
          err_d  = 1'b1;
          code_d = 2'b10;
        end else begin
          value_d = {2'b00, tens_l_q} * 6'd10
                  + {2'b00, units_l_q};
          tens_bcd_d  = tens_l_q;
          units_bcd_d = units_l_q;
          vv_d        = 1'b1;
        end
      end
      default: state_d = WAIT_TENS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '0;
      sel_q       <= '0;
      seg_p_q     <= '0;
      sel_p_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      state_q     <= WAIT_TENS;
      tens_l_q    <= '0;
      units_l_q   <= '0;
      value_q     <= '0;
      tens_bcd_q  <= '0;
      units_bcd_q <= '0;
      vv_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
    end else begin
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      seg_p_q     <= seg_p_d;
      sel_p_q     <= sel_p_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      state_q     <= state_d;
      tens_l_q    <= tens_l_d;
      units_l_q   <= units_l_d;
      value_q     <= value_d;
      tens_bcd_q  <= tens_bcd_d;
      units_bcd_q <= units_bcd_d;
      vv_q        <= vv_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.tens_bcd    = tens_bcd_q;
  assign bus.units_bcd   = units_bcd_q;
  assign bus.value_valid = vv_q;
  assign bus.err         = err_q;
  assign bus.err_code    = code_q;

endmodule

// File: tb/tb_segments_decoder.sv
// Scoreboard bench for segments_decoder: run-based stimulus,
// digit-level reference model, decoupled output monitor.
module tb_segments_decoder;

  localparam int S = 4;
  localparam int T = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  segments_decoder_if bus();

  segments_decoder #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         value;
    int         exp_cyc;
  } ev_t;

  ev_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] pat [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  bit m_wu = 0;
  int m_tens = 0;
  int t_latch = 0;
  int last_value = 0;
  logic [1:0] last_sel = 2'b00;
  logic [6:0] last_seg = 7'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_err(input logic [1:0] code);
    q.push_back('{1'b1, code, last_value, -1});
  endfunction

  // Digit-level model: a run of length >= S on a selected digit is one
  // acceptance at (run start + S - 1); timeouts are measured between those.
  function automatic void model_run(input logic [1:0] sel, input logic [6:0] seg,
                                    input int len, input int k, input bit lat);
    int d;
    bit acc;
    int a;
    d = -1;
    for (int i = 0; i < 10; i++) if (pat[i] == seg) d = i;
    acc = ((sel == 2'b10) || (sel == 2'b01)) && (len >= S);
    a = k + S - 1;
    if (m_wu) begin
      if (acc && (a > t_latch + T)) begin
        push_err(2'b11);
        m_wu = 0;
      end else if (!acc && (k + len + S - 1 > t_latch + T)) begin
        push_err(2'b11);
        m_wu = 0;
      end
    end
    if (!acc) return;
    if (!m_wu) begin
      if (sel == 2'b10) begin
        if (d < 0) push_err(2'b01);
        else begin
          m_tens = d;
          m_wu = 1;
          t_latch = a;
        end
      end
    end else if (sel == 2'b01) begin
      m_wu = 0;
      if (d < 0) push_err(2'b01);
      else if (m_tens > 5) push_err(2'b10);
      else begin
        last_value = m_tens * 10 + d;
        q.push_back('{1'b0, 2'b00, last_value, lat ? k + S + 1 : -1});
      end
    end else begin
      if (d < 0) begin
        push_err(2'b01);
        m_wu = 0;
      end else begin
        m_tens = d;
        t_latch = a;
      end
    end
  endfunction

  task automatic drive_run(input logic [1:0] sel, input logic [6:0] seg,
                           input int len, input bit lat = 0);
    model_run(sel, seg, len, cyc + 1, lat);
    bus.dig_sel = sel;
    bus.seg_in = seg;
    last_sel = sel;
    last_seg = seg;
    repeat (len) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.value_valid || bus.err)) begin
      ev_t e;
      chk("exclusive", int'(bus.value_valid && bus.err), 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: valid=%0d err=%0d code=%0d value=%0d none expected",
                 bus.value_valid, bus.err, bus.err_code, bus.value);
      end else begin
        e = q.pop_front();
        chk("event_is_err", int'(bus.err), int'(e.is_err));
        if (e.is_err) begin
          chk("err_code", int'(bus.err_code), int'(e.code));
          chk("value_held", int'(bus.value), e.value);
        end else begin
          chk("value", int'(bus.value), e.value);
          chk("tens_bcd", int'(bus.tens_bcd), e.value / 10);
          chk("units_bcd", int'(bus.units_bcd), e.value % 10);
          if (e.exp_cyc >= 0) chk("latency", cyc, e.exp_cyc);
        end
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check_zero(input string tag);
    chk({tag, "_value"}, int'(bus.value), 0);
    chk({tag, "_tens"}, int'(bus.tens_bcd), 0);
    chk({tag, "_units"}, int'(bus.units_bcd), 0);
    chk({tag, "_valid"}, int'(bus.value_valid), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_code"}, int'(bus.err_code), 0);
  endtask

  initial begin
    logic [1:0] sel;
    logic [6:0] seg;
    int len;
    int r;
    bus.seg_in = '0;
    bus.dig_sel = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    drive_run(2'b10, 7'b1011011, 6);
    drive_run(2'b01, 7'b1111011, 6, 1'b1);
    drive_run(2'b00, 7'd0, 4);

    drive_run(2'b10, pat[3], S - 1);
    drive_run(2'b10, 7'b0000000, 1);
    drive_run(2'b00, 7'd0, 4);

    drive_run(2'b10, 7'b1111111, 6);
    drive_run(2'b01, 7'b1111110, 6);
    drive_run(2'b00, 7'd0, 4);

    drive_run(2'b10, 7'b0000001, 6);
    drive_run(2'b10, pat[2], 6);
    drive_run(2'b01, pat[3], 6);
    drive_run(2'b00, 7'd0, 4);

    drive_run(2'b10, 7'b0110000, 6);
    drive_run(2'b00, 7'd0, T + 20);
    drive_run(2'b01, pat[4], 6);
    drive_run(2'b00, 7'd0, 4);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      sel = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 7) == 0) seg = 7'($urandom);
      else seg = pat[$urandom_range(0, 9)];
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 99) == 0) begin
        sel = 2'b00;
        len = T + $urandom_range(0, 20);
      end
      if (sel == last_sel && seg == last_seg) sel = 2'b00;
      drive_run(sel, seg, len);
    end
    drive_run(2'b00, 7'd0, T + 20);
    chk("queue_drained", q.size(), 0);

    drive_run(2'b10, pat[1], 6);
    drive_run(2'b01, pat[7], 6);
    drive_run(2'b00, 7'd0, 4);
    drive_run(2'b10, pat[4], 6);
    drive_run(2'b00, 7'd0, 2);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    m_wu = 0;
    last_value = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_run(2'b01, pat[5], 8);
    drive_run(2'b00, 7'd0, 2);
    drive_run(2'b01, pat[6], 8);
    drive_run(2'b00, 7'd0, 10);
    chk("final_drained", q.size(), 0);
    chk("final_value", int'(bus.value), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
